// File: rtl/nexi_uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte streams.
// Grant is held for a whole message; a per-byte watchdog and a hold timer release it.
module nexi_uart_tx_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 65535,
   parameter int HOLD_CYCLES    = 255
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]            req_last_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   output logic [NUM_REQ-1:0]            grant_o,
   output logic                          tx_send_o,
   output logic [DATA_WIDTH-1:0]         tx_data_o,
   input  logic                          tx_done_i,
   output logic                          busy_o,
   output logic                          timeout_o
);

   localparam int IDXW = $clog2(NUM_REQ);
   localparam int TW   = $clog2(TIMEOUT_CYCLES) + 1;
   localparam int HW   = $clog2(HOLD_CYCLES) + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t                 state_r;
   logic [IDXW-1:0]        owner_r;
   logic [IDXW-1:0]        last_owner_r;
   logic                   is_last_r;
   logic [TW-1:0]          timeout_cnt_r;
   logic [HW-1:0]          hold_cnt_r;
   logic [NUM_REQ-1:0]     grant_r;
   logic                   tx_send_r;
   logic [DATA_WIDTH-1:0]  tx_data_r;
   logic                   timeout_r;

   logic [IDXW-1:0]        win_s;
   logic                   found_s;
   logic [NUM_REQ-1:0]     req_ready_s;
   logic [NUM_REQ-1:0]     win_onehot_s;

   // Round-robin search starting just above the previous owner, wrapping.
   always_comb begin
      int idx;
      idx     = 0;
      win_s   = '0;
      found_s = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (int'(last_owner_r) + 1 + i) % NUM_REQ;
         if (!found_s && req_valid_i[idx]) begin
            found_s = 1'b1;
            win_s   = IDXW'(idx);
         end else begin
            found_s = found_s;
         end
      end
      win_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_s;
   end

   // Accept strobe: winner in IDLE, owner only in HOLD; forced low during reset.
   always_comb begin
      req_ready_s = '0;
      if (!rst_ni) begin
         req_ready_s = '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (found_s) begin
                  req_ready_s = win_onehot_s;
               end else begin
                  req_ready_s = '0;
               end
            end
            ST_HOLD: req_ready_s[owner_r] = req_valid_i[owner_r];
            default: req_ready_s = '0;
         endcase
      end
   end

   // Arbitration FSM with registered TX handshake, grant and timeout outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r       <= ST_IDLE;
         owner_r       <= '0;
         last_owner_r  <= IDXW'(NUM_REQ - 1);
         is_last_r     <= 1'b0;
         timeout_cnt_r <= '0;
         hold_cnt_r    <= '0;
         grant_r       <= '0;
         tx_send_r     <= 1'b0;
         tx_data_r     <= '0;
         timeout_r     <= 1'b0;
      end else begin
         timeout_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (found_s) begin
                  owner_r       <= win_s;
                  grant_r       <= win_onehot_s;
                  tx_data_r     <= req_data_i[win_s*DATA_WIDTH +: DATA_WIDTH];
                  is_last_r     <= req_last_i[win_s];
                  tx_send_r     <= 1'b1;
                  timeout_cnt_r <= '0;
                  state_r       <= ST_WAIT;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_WAIT: begin
               timeout_cnt_r <= timeout_cnt_r + TW'(1);
               if (tx_done_i) begin
                  tx_send_r <= 1'b0;
                  if (is_last_r) begin
                     last_owner_r <= owner_r;
                     grant_r      <= '0;
                     state_r      <= ST_IDLE;
                  end else begin
                     hold_cnt_r <= '0;
                     state_r    <= ST_HOLD;
                  end
               end else if (timeout_cnt_r == TW'(TIMEOUT_CYCLES - 1)) begin
                  // Abort: drop the rest of the message and let others in.
                  tx_send_r    <= 1'b0;
                  timeout_r    <= 1'b1;
                  last_owner_r <= owner_r;
                  grant_r      <= '0;
                  state_r      <= ST_IDLE;
               end else begin
                  state_r <= ST_WAIT;
               end
            end
            ST_HOLD: begin
               if (req_valid_i[owner_r]) begin
                  tx_data_r     <= req_data_i[owner_r*DATA_WIDTH +: DATA_WIDTH];
                  is_last_r     <= req_last_i[owner_r];
                  tx_send_r     <= 1'b1;
                  timeout_cnt_r <= '0;
                  state_r       <= ST_WAIT;
               end else if (hold_cnt_r == HW'(HOLD_CYCLES - 1)) begin
                  last_owner_r <= owner_r;
                  grant_r      <= '0;
                  state_r      <= ST_IDLE;
               end else begin
                  hold_cnt_r <= hold_cnt_r + HW'(1);
               end
            end
            default: begin
               tx_send_r <= 1'b0;
               grant_r   <= '0;
               state_r   <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready_o = req_ready_s;
   assign grant_o     = grant_r;
   assign tx_send_o   = tx_send_r;
   assign tx_data_o   = tx_data_r;
   assign busy_o      = (state_r != ST_IDLE);
   assign timeout_o   = timeout_r;

endmodule

// File: doc/nexi_uart_tx_arbiter.md
# nexi_uart_tx_arbiter

Round-robin scheduler that shares one UART transmitter between `NUM_REQ` byte-stream requesters.
- It sequences the transmitter's level send / done handshake one byte at a time.
- It keeps a requester's grant until that requester's message (marked by `last`) completes.
- It protects the shared transmitter with a per-byte completion watchdog and a mid-message stall release.
- It sits between the UART's bus-facing register logic / DMA-style producers and the UART TX core.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, range 2..8.
- `DATA_WIDTH`, 8: byte width.
- `TIMEOUT_CYCLES`, 65535: maximum `WAIT` cycles for `tx_done_i` before abort. Must be ≥1.
- `HOLD_CYCLES`, 255: maximum `HOLD` cycles for the owner to present its next byte. Must be ≥1.

Ports:
- `clk_i`  in  1  single clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  NUM_REQ  requester k has a byte.
- `req_data_i`  in  NUM_REQ*DATA_WIDTH  requester k byte at `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `req_last_i`  in  NUM_REQ  byte of requester k ends its message.
- `req_ready_o`  out  NUM_REQ  one-hot, combinational; byte accepted on this edge.
- `grant_o`  out  NUM_REQ  one-hot current owner, 0 when free.
- `tx_send_o`  out  1  level request to TX core.
- `tx_data_o`  out  DATA_WIDTH  byte to TX core; stable while `tx_send_o`=1.
- `tx_done_i`  in  1  one-cycle pulse from TX core: byte fully shifted out.
- `busy_o`  out  1  state≠`IDLE`.
- `timeout_o`  out  1  one-cycle pulse on watchdog abort.

## Operation
- Registers: `state` (`IDLE`, `WAIT`, `HOLD`), `owner`, `last_owner`, `is_last` flag, `timeout_cnt`, `hold_cnt`.
- Round-robin priority starts at `(last_owner+1) mod NUM_REQ` and searches upward with wrap. Reset sets `last_owner = NUM_REQ-1`, so requester 0 ranks first.

`IDLE`:
- `req_ready_o[w]`=1 for the winner w among asserted `req_valid_i`.
- On that edge:
  - `owner`←w, `grant_o`←onehot(w).
  - `tx_data_o`←byte w, `is_last`←`req_last_i[w]`.
  - `tx_send_o`←1, `timeout_cnt`←0, state←`WAIT`.

`WAIT`:
- `req_ready_o`=0; `timeout_cnt` increments each cycle.
- On `tx_done_i`, `tx_send_o`←0, then:
  - if `is_last`: `last_owner`←`owner`, `grant_o`←0, state←`IDLE`.
  - else: `hold_cnt`←0, state←`HOLD`.
- Else, if `timeout_cnt`=`TIMEOUT_CYCLES-1`:
  - `tx_send_o`←0, `timeout_o` pulses next cycle.
  - `last_owner`←`owner`, `grant_o`←0, state←`IDLE`.
  - The rest of the message is dropped; the requester re-arbitrates.

`HOLD`:
- Only the owner is served: `req_ready_o[owner]` = `req_valid_i[owner]`. Other requesters are ignored.
- On accept: load the byte, `is_last`, `tx_send_o`←1, `timeout_cnt`←0, state←`WAIT`.
- Else `hold_cnt` increments. At `HOLD_CYCLES-1`: release (`last_owner`←`owner`, `grant_o`←0, state←`IDLE`).

General rules:
- `tx_done_i` outside `WAIT` is ignored.
- Simultaneous `tx_done_i` and the timeout terminal count: done wins; no `timeout_o`.
- Reset mid-operation (async): `tx_send_o`, `grant_o`, `req_ready_o` go to 0 immediately. The TX core sees the send withdrawn.

## Timing
Reset values:
- `tx_send_o`=0, `tx_data_o`=0, `grant_o`=0, `busy_o`=0, `timeout_o`=0, `req_ready_o`=0.
- state=`IDLE`.

Latencies:
- Valid in `IDLE` at cycle N: `req_ready_o` at N, `tx_send_o`/`grant_o` high from N+1.
- `tx_done_i` at M: `tx_send_o` low at M+1. The owner's next byte is accepted at M+1 at the earliest, with `tx_send_o` high at M+2. This guarantees a one-cycle send-low gap between bytes.
- After a `last` byte completes at M: a new grant is accepted in `IDLE` at M+1.
- Requesters must hold valid/data/last stable until `req_ready_o`.

## Test plan
- Single requester 1 sends 0x41 (last) with `tx_done_i` 10 cycles after send -> `req_ready_o`=0b0010 at N, `tx_data_o`=0x41 and `tx_send_o`=1 from N+1 to done+1, `grant_o` 0 after.
- Requesters 0 and 2 both send one-byte messages continuously -> grants alternate 0,2,0,2; requester 0 first after reset.
- Requester 3 sends 3-byte message 0x10,0x11,0x12(last) while requester 0 is valid -> all three bytes go out before requester 0 is granted; `tx_send_o` low ≥1 cycle between bytes.
- TIMEOUT_CYCLES=16, `tx_done_i` never pulses -> `tx_send_o` drops after 16 `WAIT` cycles, `timeout_o` pulses once, next requester granted.
- HOLD_CYCLES=8, owner drops valid after a non-last byte -> grant released after 8 `HOLD` cycles. `tx_done_i` pulse while `IDLE` has no effect.
- Assert `rst_ni`=0 mid-`WAIT` -> `tx_send_o`, `grant_o` go to 0 without a clock edge; after release, requester 0 has first priority.
